match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter STEP_FRAMES, default 30, frame_ticks per countdown step.
REQ-002 SHALL have parameter POINT_FRAMES, default 60, frame_ticks of the post-point hold.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 SHALL have port start  input  1  one-cycle pulse: begin or restart a match.
REQ-007 SHALL have port serve  input  1  one-cycle pulse: request serve.
REQ-008 SHALL have port point_p1 / point_p2  input  1 each  one-cycle pulse: ball passed P2 / P1 edge, scoring player 1 / player 2.
REQ-009 SHALL have port max_score  input  2  target select: 00=3, 01=5, 10=7, 11=11.
REQ-010 SHALL have port serve_type  input  1  0 = alternate server, 1 = loser of point serves.
REQ-011 SHALL have port state  output  3  IDLE=0, READY=1, COUNTDOWN=2, RALLY=3, POINT=4, GAME_OVER=5.
REQ-012 SHALL have port ball_en  output  1  high only in RALLY.
REQ-013 SHALL have port ball_reset  output  1  one-cycle pulse: recentre ball.
REQ-014 SHALL have port serve_dir  output  1  0 = P1 serves (ball toward P2), 1 = P2 serves.
REQ-015 SHALL have port countdown  output  2  remaining countdown steps for display.
REQ-016 SHALL have port score1 / score2  output  5 each  player scores.
REQ-017 SHALL have port p1_win / p2_win  output  1 each  winner flags.

Function
REQ-018 All outputs SHALL be registered; a response to any input pulse SHALL appear on the cycle after the sampling edge.
REQ-019 In IDLE: outputs hold; on start → clear scores, clear win flags, serve_dir=0, latch target from max_score, pulse ball_reset, go to READY.
REQ-020 start in any state other than IDLE SHALL perform the same match restart as REQ-019 (abort in progress), taking priority over all other inputs that cycle.
REQ-021 max_score SHALL be sampled only at match start; later changes SHALL NOT affect the running match.
REQ-022 In READY: on serve → countdown=3, clear frame counter, go to COUNTDOWN; serve in any other state SHALL be ignored.
REQ-023 In COUNTDOWN: frame counter SHALL increment per frame_tick; at STEP_FRAMES ticks it SHALL clear and countdown SHALL decrement; a decrement from 1 to 0 SHALL move to RALLY with ball_en=1.
REQ-024 In RALLY: point_p1 alone → score1+1; point_p2 alone → score2+1; both in the same cycle → no score change, remain in RALLY.
REQ-025 After a score, if the new score equals the target → GAME_OVER, set the corresponding winner flag, ball_en=0; otherwise → POINT.
REQ-026 Entry to POINT SHALL pulse ball_reset, drop ball_en, clear frame counter, and update serve_dir: serve_type=0 toggles; serve_type=1 sets serve_dir toward the point loser (point_p1 → 1, point_p2 → 0).
REQ-027 POINT SHALL last POINT_FRAMES frame_ticks, then go to READY.
REQ-028 point pulses outside RALLY SHALL be ignored.
REQ-029 GAME_OVER SHALL hold scores and win flags until start.
REQ-030 Scores SHALL never exceed the target; at most one winner flag SHALL be high.
REQ-031 frame_tick coinciding with a state-changing event SHALL be consumed by the new state's counter clear (no carry-over).

Reset
REQ-032 While rst is low: state=IDLE, scores=0, win flags=0, ball_en=0, ball_reset=0, serve_dir=0, countdown=0, frame counter=0, target=3.
REQ-033 Reset assertion mid-match SHALL abort immediately, asynchronously, to the REQ-032 values.

Verification
REQ-034 Reset, start, serve, 90 frame_ticks → countdown steps 3,2,1 then RALLY with ball_en=1 on the 90th tick + 1 cycle.
REQ-035 max_score=00, three point_p1 in RALLY (with POINT/serve cycles between) → score1=3, p1_win=1, state=GAME_OVER, score2=0.
REQ-036 serve_type=0, two points → serve_dir 0→1→0; serve_type=1, point_p2 → serve_dir=0 (P1 lost, P1 serves).
REQ-037 point_p1 and point_p2 same cycle in RALLY → scores unchanged, state=RALLY.
REQ-038 start during COUNTDOWN with score 2:1 → scores 0:0, state=READY, ball_reset pulse; rst low mid-RALLY → all REQ-032 values immediately.

Source files
------------

// File: rtl/match_controller.sv
// Match sequencing for a two-player paddle game: serve countdown, rally,
// point hold, scoring to a selectable target and winner flags.
module match_controller #(
  parameter int unsigned STEP_FRAMES  = 30,
  parameter int unsigned POINT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       serve,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic [1:0] max_score,
  input  logic       serve_type,
  output logic [2:0] state,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [1:0] countdown,
  output logic [4:0] score1,
  output logic [4:0] score2,
  output logic       p1_win,
  output logic       p2_win
);

  localparam int unsigned MAX_FRAMES = (STEP_FRAMES > POINT_FRAMES) ? STEP_FRAMES : POINT_FRAMES;
  localparam int unsigned FCNT_W     = $clog2(MAX_FRAMES + 1);
  localparam int unsigned SCORE_W    = 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READY     = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_RALLY     = 3'd3,
    S_POINT     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  state_t              st_q, st_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [1:0]          cd_q, cd_d;
  logic [SCORE_W-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [SCORE_W-1:0]  target_q, target_d;
  logic [SCORE_W-1:0]  new_score;
  logic                w1_q, w1_d, w2_q, w2_d;
  logic                ben_q, ben_d, brst_q, brst_d, sdir_q, sdir_d;

  function automatic logic [SCORE_W-1:0] target_of(input logic [1:0] sel);
    case (sel)
      2'b00:   target_of = SCORE_W'(3);
      2'b01:   target_of = SCORE_W'(5);
      2'b10:   target_of = SCORE_W'(7);
      default: target_of = SCORE_W'(11);
    endcase
  endfunction

  // State and all output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= S_IDLE;
      fcnt_q   <= '0;
      cd_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      target_q <= SCORE_W'(3);
      w1_q     <= 1'b0;
      w2_q     <= 1'b0;
      ben_q    <= 1'b0;
      brst_q   <= 1'b0;
      sdir_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      fcnt_q   <= fcnt_d;
      cd_q     <= cd_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      target_q <= target_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      ben_q    <= ben_d;
      brst_q   <= brst_d;
      sdir_q   <= sdir_d;
    end
  end

  // Next-state logic; start overrides everything and restarts the match
  always_comb begin
    st_d      = st_q;
    fcnt_d    = fcnt_q;
    cd_d      = cd_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    target_d  = target_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    ben_d     = ben_q;
    brst_d    = 1'b0;
    sdir_d    = sdir_q;
    new_score = point_p1 ? (s1_q + SCORE_W'(1)) : (s2_q + SCORE_W'(1));

    if (start) begin
      st_d     = S_READY;
      fcnt_d   = '0;
      cd_d     = '0;
      s1_d     = '0;
      s2_d     = '0;
      target_d = target_of(max_score);
      w1_d     = 1'b0;
      w2_d     = 1'b0;
      ben_d    = 1'b0;
      brst_d   = 1'b1;
      sdir_d   = 1'b0;
    end else begin
      case (st_q)
        S_READY: begin
          if (serve) begin
            st_d   = S_COUNTDOWN;
            cd_d   = 2'd3;
            fcnt_d = '0;
          end
        end
        S_COUNTDOWN: begin
          if (frame_tick) begin
            if (fcnt_q == FCNT_W'(STEP_FRAMES - 1)) begin
              fcnt_d = '0;
              cd_d   = cd_q - 2'd1;
              if (cd_q == 2'd1) begin
                st_d  = S_RALLY;
                ben_d = 1'b1;
              end
            end else begin
              fcnt_d = fcnt_q + FCNT_W'(1);
            end
          end
        end
        S_RALLY: begin
          // Simultaneous points cancel out and the rally continues
          if (point_p1 ^ point_p2) begin
            if (point_p1) s1_d = new_score;
            else          s2_d = new_score;
            ben_d = 1'b0;
            if (new_score == target_q) begin
              st_d = S_GAME_OVER;
              w1_d = point_p1;
              w2_d = point_p2;
            end else begin
              st_d   = S_POINT;
              brst_d = 1'b1;
              fcnt_d = '0;
              sdir_d = serve_type ? point_p1 : ~sdir_q;
            end
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            if (fcnt_q == FCNT_W'(POINT_FRAMES - 1)) begin
              fcnt_d = '0;
              st_d   = S_READY;
            end else begin
              fcnt_d = fcnt_q + FCNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state      = st_q;
  assign ball_en    = ben_q;
  assign ball_reset = brst_q;
  assign serve_dir  = sdir_q;
  assign countdown  = cd_q;
  assign score1     = s1_q;
  assign score2     = s2_q;
  assign p1_win     = w1_q;
  assign p2_win     = w2_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: directed stimulus queues expected
// output snapshots, a negedge monitor pops and compares them.
module tb_match_controller;

  logic       clk, rst, frame_tick, start, serve, point_p1, point_p2, serve_type;
  logic [1:0] max_score;
  logic [2:0] state;
  logic       ball_en, ball_reset, serve_dir, p1_win, p2_win;
  logic [1:0] countdown;
  logic [4:0] score1, score2;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       w1;
    logic       w2;
    logic       ben;
    logic       brst;
    logic       sdir;
    logic [1:0] cd;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  match_controller #(.STEP_FRAMES(30), .POINT_FRAMES(60)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .serve(serve),
    .point_p1(point_p1), .point_p2(point_p2), .max_score(max_score),
    .serve_type(serve_type), .state(state), .ball_en(ball_en),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .countdown(countdown),
    .score1(score1), .score2(score2), .p1_win(p1_win), .p2_win(p2_win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string snap_str(input snap_t s);
    return $sformatf("st=%0d s1=%0d s2=%0d w1=%0b w2=%0b ben=%0b brst=%0b sdir=%0b cd=%0d",
                     s.st, s.s1, s.s2, s.w1, s.w2, s.ben, s.brst, s.sdir, s.cd);
  endfunction

  // Monitor: compares the DUT outputs against the oldest queued expectation
  always @(negedge clk) begin
    snap_t e, a;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{st: state, s1: score1, s2: score2, w1: p1_win, w2: p2_win,
            ben: ball_en, brst: ball_reset, sdir: serve_dir, cd: countdown};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got {%s} expected {%s}", n, snap_str(a), snap_str(e));
      end
    end
  end

  task automatic expect_out(input string nm, input int st, input int s1, input int s2,
                            input logic w1, input logic w2, input logic ben,
                            input logic brst, input logic sdir, input int cd);
    snap_t s;
    s = '{st: 3'(st), s1: 5'(s1), s2: 5'(s2), w1: w1, w2: w2,
          ben: ben, brst: brst, sdir: sdir, cd: 2'(cd)};
    exp_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic start_m(input logic [1:0] ms);
    @(posedge clk); #1 start = 1'b1; max_score = ms;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic serve_p();
    @(posedge clk); #1 serve = 1'b1;
    @(posedge clk); #1 serve = 1'b0;
  endtask

  task automatic point(input logic a, input logic b);
    @(posedge clk); #1 point_p1 = a; point_p2 = b;
    @(posedge clk); #1 point_p1 = 1'b0; point_p2 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
    end
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve_rally();
    serve_p();
    ticks(90);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; serve = 1'b0;
    point_p1 = 1'b0; point_p2 = 1'b0; max_score = 2'b00; serve_type = 1'b0;
    #1 expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Countdown timing and first rally
    start_m(2'b00);  expect_out("start",       1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);         expect_out("brst_drop",   1, 0, 0, 0, 0, 0, 0, 0, 0);
    serve_p();       expect_out("serve",       2, 0, 0, 0, 0, 0, 0, 0, 3);
    ticks(29);       expect_out("cd_29",       2, 0, 0, 0, 0, 0, 0, 0, 3);
    ticks(1);        expect_out("cd_30",       2, 0, 0, 0, 0, 0, 0, 0, 2);
    ticks(30);       expect_out("cd_60",       2, 0, 0, 0, 0, 0, 0, 0, 1);
    ticks(30);       expect_out("cd_90",       3, 0, 0, 0, 0, 1, 0, 0, 0);
    point(1, 1);     expect_out("both_pts",    3, 0, 0, 0, 0, 1, 0, 0, 0);
    serve_p();       expect_out("serve_rally", 3, 0, 0, 0, 0, 1, 0, 0, 0);

    // Alternating server, point hold, ignored pulses
    point(1, 0);     expect_out("pt1_a",       4, 1, 0, 0, 0, 0, 1, 1, 0);
    point(0, 1);     expect_out("pt_in_point", 4, 1, 0, 0, 0, 0, 0, 1, 0);
    ticks(59);       expect_out("point_59",    4, 1, 0, 0, 0, 0, 0, 1, 0);
    ticks(1);        expect_out("point_60",    1, 1, 0, 0, 0, 0, 0, 1, 0);
    serve_rally();   expect_out("rally2",      3, 1, 0, 0, 0, 1, 0, 1, 0);
    point(1, 0);     expect_out("pt1_b",       4, 2, 0, 0, 0, 0, 1, 0, 0);
    ticks(60); serve_rally();
    point(1, 0);     expect_out("win_p1",      5, 3, 0, 1, 0, 0, 0, 0, 0);
    serve_p();       expect_out("serve_go",    5, 3, 0, 1, 0, 0, 0, 0, 0);
    point(0, 1);     expect_out("pt_go",       5, 3, 0, 1, 0, 0, 0, 0, 0);

    // Loser serves, target latched at 5 despite max_score changing
    serve_type = 1'b1;
    start_m(2'b01);  expect_out("start5",      1, 0, 0, 0, 0, 0, 1, 0, 0);
    max_score = 2'b00;
    serve_rally(); point(0, 1); expect_out("lose_p1",  4, 0, 1, 0, 0, 0, 1, 0, 0);
    ticks(60); serve_rally(); point(1, 0); expect_out("lose_p2", 4, 1, 1, 0, 0, 0, 1, 1, 0);
    ticks(60); serve_rally(); point(0, 1); expect_out("p2_two",  4, 1, 2, 0, 0, 0, 1, 0, 0);
    ticks(60); serve_rally(); point(0, 1); expect_out("tgt_kept", 4, 1, 3, 0, 0, 0, 1, 0, 0);
    ticks(60); serve_rally(); point(0, 1); expect_out("p2_four", 4, 1, 4, 0, 0, 0, 1, 0, 0);
    ticks(60); serve_rally(); point(0, 1); expect_out("win_p2",  5, 1, 5, 0, 1, 0, 0, 0, 0);

    // Restart during countdown at 2:1
    serve_type = 1'b0;
    start_m(2'b00);  expect_out("start3",      1, 0, 0, 0, 0, 0, 1, 0, 0);
    serve_rally(); point(1, 0);
    ticks(60); serve_rally(); point(0, 1);
    ticks(60); serve_rally(); point(1, 0); expect_out("score_2_1", 4, 2, 1, 0, 0, 0, 1, 1, 0);
    ticks(60); serve_p(); ticks(10);       expect_out("cd_mid",    2, 2, 1, 0, 0, 0, 0, 1, 3);
    start_m(2'b00);  expect_out("abort",       1, 0, 0, 0, 0, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a rally
    serve_rally();   expect_out("pre_rst",     3, 0, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2 rst = 1'b0;
    #1 expect_out("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
